led_blink_arbiter: RTL and testbench
====================================

// Module: led_blink_arbiter
// PURPOSE
//  Shares one board LED between N_REQ requesters (self-test, link status, error reporting...).
//  Each requester asks for a blink burst: on time, off time and blink count.
//  A round-robin arbiter grants the LED to one requester, then an on/off timer FSM plays the burst.
//  Sits between status logic and the LED pin, replacing free-running per-feature blinkers.
// PARAMETERS
//  N_REQ   4           number of requesters (2..8)
//  CLK_HZ  25_000_000  clk_i frequency, Hz
//  TICK_HZ 1000        timing tick rate; on/off times are counted in ticks (1 ms at default)
//  CNT_W   8           width of the blink-count field
// PORTS
//  clk_i      in   1            system clock
//  rst_i      in   1            asynchronous reset, active-high
//  req_i      in   N_REQ        per-requester request level; held until done_o or abort
//  on_t_i     in   N_REQ*16     per-requester LED-on time in ticks (slice k = [16k+15:16k])
//  off_t_i    in   N_REQ*16     per-requester LED-off time in ticks
//  blinks_i   in   N_REQ*CNT_W  per-requester number of on/off cycles
//  gnt_o      out  N_REQ        one-hot grant; high for the whole burst
//  done_o     out  N_REQ        one-cycle pulse on the served requester's bit at burst end
//  busy_o     out  1            high whenever the state is not IDLE
//  led_o      out  1            LED drive, 1 = on
// BEHAVIOUR
//  Reset: state IDLE; gnt_o=0, done_o=0, busy_o=0, led_o=0; rr pointer=N_REQ-1; prescaler=0.
//  DIV = CLK_HZ/TICK_HZ (integer; elaboration error if < 2). Prescaler counts 0..DIV-1; tick=1 at DIV-1.
//  Prescaler is cleared on entry to ON and OFF, so each phase lasts exactly T*DIV cycles.
//  Times are 16-bit; T=0 is treated as T=1. Phase counter is 16 bits and never wraps.
//  FSM:
//   IDLE : if any req_i, winner = first set bit searching upward from rr+1 (mod N_REQ).
//          Next cycle -> LOAD. If no req_i, remain in IDLE.
//   LOAD : gnt_o[winner]=1; latch on_t, off_t and blinks of the winner (later input changes are ignored).
//          If blinks=0 -> DONE, else -> ON.
//   ON   : led_o=1; count ticks. When count reaches on_t -> OFF.
//   OFF  : led_o=0; count ticks. At off_t, decrement remaining.
//          If remaining is 0 -> DONE, else -> ON.
//   DONE : one cycle; done_o[winner]=1, gnt_o=0, led_o=0, rr=winner -> IDLE.
//  Latency: req_i rise (LED idle) -> gnt_o at +2 cycles -> led_o=1 at +3 cycles.
//  Abort: if req_i[winner] drops in LOAD/ON/OFF -> IDLE next cycle, led_o=0, gnt_o=0, no done_o.
//         rr is set to winner.
//  Requests arriving during a burst wait; no preemption. After DONE, IDLE re-arbitrates the same cycle.
//  A requester still asserting req_i after done_o gets a new burst, but only after other pending requests.
//  led_o, gnt_o, done_o and busy_o are registered (no combinational path from inputs).
//  rst_i asserted mid-burst: immediate return to reset values; no done_o.
// STRUCTURE
//  Package led_ctrl_pkg: state enum {IDLE,LOAD,ON,OFF,DONE}; function div_f(CLK_HZ,TICK_HZ); TIME_W=16.
//  Sub-module led_tick_gen: prescaler with synchronous clear_i, output tick_o; parameter DIV.
//  Top contains the round-robin picker (priority search on rotated vector), parameter latches and FSM.
// TESTING (CLK_HZ=1000, TICK_HZ=100 -> DIV=10, N_REQ=4)
//  1 Single req: req_i=0001, on=2, off=3, blinks=2 -> gnt_o=0001 at +2 cycles; led_o high 20 cycles,
//    low 30, high 20, low 30; done_o=0001 once; busy_o=0 next cycle.
//  2 Round robin: req_i=1111 held, blinks=1 each -> grant order 0,1,2,3,0; each done_o pulse is one cycle.
//  3 blinks=0 on req 2 -> LOAD then DONE; led_o never 1; done_o=0100 at +3 cycles.
//  4 Abort: drop req_i[1] mid-ON -> led_o=0, gnt_o=0 next cycle, no done_o; pending req 3 granted next.
//  5 on=0, off=0, blinks=3 -> each phase lasts 10 cycles (zero treated as one tick).
//  6 Assert rst_i mid-OFF -> all outputs 0 immediately; after release, req_i=0001 restarts the burst cleanly.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_ctrl_pkg
//  Description : Shared types and helpers for the LED blink arbiter.
//                state_t  - burst FSM states
//                TIME_W   - width of on/off time fields (ticks)
//                div_f()  - clock-to-tick prescaler ratio
//  Revision    : 1.0 - initial release
// ============================================================================
package led_ctrl_pkg;

    localparam int TIME_W = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ON   = 3'd2,
        OFF  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Number of clk cycles per timing tick. A zero tick rate yields 0 so the
    // elaboration check in the top rejects it instead of dividing by zero.
    function automatic int div_f(input int clk_hz, input int tick_hz);
        if (tick_hz <= 0) begin
            return 0;
        end
        return clk_hz / tick_hz;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : led_tick_gen
//  Description : Free-running prescaler counting 0..DIV-1; tick_o is high
//                during the count DIV-1. clear_i restarts the count at 0 on
//                the next edge so a phase can start on a full tick period.
//  Ports       : clk_i   - system clock
//                rst_i   - asynchronous reset, active-high
//                clear_i - synchronous restart of the prescaler
//                tick_o  - one-cycle tick strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module led_tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (clear_i || (r_cnt == C_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick_o = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/led_blink_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : led_blink_arbiter
//  Description : Shares one LED between N_REQ requesters. A round-robin
//                picker grants the LED to one requester, whose on time,
//                off time and blink count are latched and played out by a
//                tick-timed on/off FSM. All outputs are registered and show
//                the state of the previous cycle.
//  Ports       : clk_i    - system clock
//                rst_i    - asynchronous reset, active-high
//                req_i    - per-requester request level
//                on_t_i   - per-requester on time in ticks  (16 bits each)
//                off_t_i  - per-requester off time in ticks (16 bits each)
//                blinks_i - per-requester blink count (CNT_W bits each)
//                gnt_o    - one-hot grant, high during the burst
//                done_o   - one-cycle pulse at burst end
//                busy_o   - FSM not idle
//                led_o    - LED drive, 1 = on
//  Revision    : 1.0 - initial release
// ============================================================================
module led_blink_arbiter
    import led_ctrl_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int CLK_HZ  = 25_000_000,
    parameter int TICK_HZ = 1000,
    parameter int CNT_W   = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*TIME_W-1:0]   on_t_i,
    input  logic [N_REQ*TIME_W-1:0]   off_t_i,
    input  logic [N_REQ*CNT_W-1:0]    blinks_i,
    output logic [N_REQ-1:0]          gnt_o,
    output logic [N_REQ-1:0]          done_o,
    output logic                      busy_o,
    output logic                      led_o
);

    localparam int DIV   = div_f(CLK_HZ, TICK_HZ);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] C_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    generate
        if (DIV < 2) begin : g_div_check
            $error("led_blink_arbiter: CLK_HZ/TICK_HZ must be at least 2");
        end
        if ((N_REQ < 2) || (N_REQ > 8)) begin : g_nreq_check
            $error("led_blink_arbiter: N_REQ must be in 2..8");
        end
    endgenerate

    state_t              r_state;
    state_t              w_next;
    logic [IDX_W-1:0]    r_rr;
    logic [IDX_W-1:0]    r_win;
    logic [IDX_W-1:0]    w_pick;
    logic                w_any;
    logic [TIME_W-1:0]   r_on_t;
    logic [TIME_W-1:0]   r_off_t;
    logic [CNT_W-1:0]    r_rem;
    logic [TIME_W-1:0]   r_ph;
    logic [TIME_W-1:0]   w_on_last;
    logic [TIME_W-1:0]   w_off_last;
    logic [TIME_W-1:0]   w_on_sel;
    logic [TIME_W-1:0]   w_off_sel;
    logic [CNT_W-1:0]    w_bl_sel;
    logic [N_REQ-1:0]    w_onehot;
    logic                w_in_burst;
    logic                w_abort;
    logic                w_tick;
    logic                w_clear;
    logic [N_REQ-1:0]    r_gnt;
    logic [N_REQ-1:0]    r_done;
    logic                r_busy;
    logic                r_led;

    led_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (w_clear),
        .tick_o  (w_tick)
    );

    // Round-robin pick: first request found searching upward from rr+1.
    always_comb begin
        w_pick = '0;
        w_any  = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!w_any && req_i[(int'(r_rr) + i) % N_REQ]) begin
                w_any  = 1'b1;
                w_pick = IDX_W'((int'(r_rr) + i) % N_REQ);
            end
        end
    end

    assign w_on_sel   = on_t_i[int'(r_win)*TIME_W +: TIME_W];
    assign w_off_sel  = off_t_i[int'(r_win)*TIME_W +: TIME_W];
    assign w_bl_sel   = blinks_i[int'(r_win)*CNT_W +: CNT_W];
    assign w_onehot   = C_ONE << r_win;

    // A time of zero behaves as one tick, so the last tick index is 0.
    assign w_on_last  = (r_on_t  == '0) ? '0 : r_on_t  - TIME_W'(1);
    assign w_off_last = (r_off_t == '0) ? '0 : r_off_t - TIME_W'(1);

    assign w_in_burst = (r_state == LOAD) || (r_state == ON) || (r_state == OFF);
    assign w_abort    = w_in_burst && !req_i[r_win];

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_next = LOAD;
                end
            end
            LOAD: begin
                if (w_abort) begin
                    w_next = IDLE;
                end else if (w_bl_sel == '0) begin
                    w_next = DONE;
                end else begin
                    w_next = ON;
                end
            end
            ON: begin
                if (w_abort) begin
                    w_next = IDLE;
                end else if (w_tick && (r_ph == w_on_last)) begin
                    w_next = OFF;
                end
            end
            OFF: begin
                if (w_abort) begin
                    w_next = IDLE;
                end else if (w_tick && (r_ph == w_off_last)) begin
                    w_next = (r_rem == CNT_W'(1)) ? DONE : ON;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Restart the prescaler whenever a timed phase is entered.
    assign w_clear = ((w_next == ON) || (w_next == OFF)) && (w_next != r_state);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_rr    <= IDX_W'(N_REQ - 1);
            r_win   <= '0;
            r_on_t  <= '0;
            r_off_t <= '0;
            r_rem   <= '0;
            r_ph    <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_led   <= 1'b0;
        end else begin
            r_state <= w_next;

            if ((r_state == IDLE) && w_any) begin
                r_win <= w_pick;
            end

            if (r_state == LOAD) begin
                r_on_t  <= w_on_sel;
                r_off_t <= w_off_sel;
                r_rem   <= w_bl_sel;
            end else if ((r_state == OFF) && (w_next == ON)) begin
                r_rem   <= r_rem - CNT_W'(1);
            end

            if (w_clear) begin
                r_ph <= '0;
            end else if (w_tick && ((r_state == ON) || (r_state == OFF))) begin
                r_ph <= r_ph + TIME_W'(1);
            end

            if ((r_state == DONE) || w_abort) begin
                r_rr <= r_win;
            end

            // Outputs decode the current state; an abort clears them on the
            // same edge that returns the FSM to IDLE.
            r_gnt  <= (w_in_burst && !w_abort) ? w_onehot : '0;
            r_done <= (r_state == DONE) ? w_onehot : '0;
            r_busy <= (r_state != IDLE) && !w_abort;
            r_led  <= (r_state == ON) && !w_abort;
        end
    end

    assign gnt_o  = r_gnt;
    assign done_o = r_done;
    assign busy_o = r_busy;
    assign led_o  = r_led;

endmodule
`default_nettype wire

// File: tb/tb_led_blink_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_blink_arbiter
//  Description : Self-checking bench for led_blink_arbiter (N_REQ=4,
//                CLK_HZ=1000, TICK_HZ=100 -> 10 clk cycles per tick).
//                A timeline model expands each granted burst into a queue of
//                expected per-cycle outputs; directed scenarios add
//                hand-computed latency and phase-length checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_blink_arbiter;

    localparam int N   = 4;
    localparam int DIV = 10;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] on_t;
    logic [63:0] off_t;
    logic [31:0] blinks;
    logic [3:0]  gnt_o;
    logic [3:0]  done_o;
    logic        busy_o;
    logic        led_o;

    int n_assert = 0;
    int n_fail   = 0;

    led_blink_arbiter #(
        .N_REQ   (N),
        .CLK_HZ  (1000),
        .TICK_HZ (100),
        .CNT_W   (8)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (req),
        .on_t_i   (on_t),
        .off_t_i  (off_t),
        .blinks_i (blinks),
        .gnt_o    (gnt_o),
        .done_o   (done_o),
        .busy_o   (busy_o),
        .led_o    (led_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    typedef struct packed {
        logic [3:0] gnt;
        logic [3:0] done;
        logic       busy;
        logic       led;
        logic [1:0] kind;   // 0 = grant cycle, 1 = lit/dark cycle, 2 = done cycle
    } tup_t;

    tup_t       q[$];
    tup_t       t;
    logic [3:0] m_gnt  = '0;
    logic [3:0] m_done = '0;
    logic       m_busy = 1'b0;
    logic       m_led  = 1'b0;
    int         m_rr   = 3;
    int         m_w    = 0;
    bit         found;

    function automatic tup_t mk(logic [3:0] g, logic [3:0] d, logic b, logic l, logic [1:0] k);
        tup_t r;
        r.gnt = g; r.done = d; r.busy = b; r.led = l; r.kind = k;
        return r;
    endfunction

    task automatic build_burst(input int w);
        int on_c, off_c, nb;
        logic [3:0] g;
        g     = 4'b0001 << w;
        on_c  = int'(on_t[w*16 +: 16]);
        off_c = int'(off_t[w*16 +: 16]);
        nb    = int'(blinks[w*8 +: 8]);
        if (on_c == 0)  on_c  = 1;
        if (off_c == 0) off_c = 1;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < on_c * DIV; c++)  q.push_back(mk(g, 4'b0, 1'b1, 1'b1, 2'd1));
            for (int c = 0; c < off_c * DIV; c++) q.push_back(mk(g, 4'b0, 1'b1, 1'b0, 2'd1));
        end
        q.push_back(mk(4'b0, g, 1'b1, 1'b0, 2'd2));
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                q.delete();
                m_rr = 3; m_w = 0;
                m_gnt = '0; m_done = '0; m_busy = 1'b0; m_led = 1'b0;
            end else if (q.size() == 0) begin
                m_gnt = '0; m_done = '0; m_busy = 1'b0; m_led = 1'b0;
                if (req != 4'b0) begin
                    found = 1'b0;
                    for (int i = 1; i <= N; i++) begin
                        if (!found && req[(m_rr + i) % N]) begin
                            found = 1'b1;
                            m_w   = (m_rr + i) % N;
                        end
                    end
                    q.push_back(mk(4'b0001 << m_w, 4'b0, 1'b1, 1'b0, 2'd0));
                end
            end else begin
                t = q.pop_front();
                if ((t.kind != 2'd2) && !req[m_w]) begin
                    q.delete();
                    m_gnt = '0; m_done = '0; m_busy = 1'b0; m_led = 1'b0;
                    m_rr  = m_w;
                end else begin
                    m_gnt = t.gnt; m_done = t.done; m_busy = t.busy; m_led = t.led;
                    if (t.kind == 2'd0) build_burst(m_w);
                    if (t.kind == 2'd2) m_rr = m_w;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_gnt",  {28'd0, gnt_o},  {28'd0, m_gnt});
            chk("model_done", {28'd0, done_o}, {28'd0, m_done});
            chk("model_busy", {31'd0, busy_o}, {31'd0, m_busy});
            chk("model_led",  {31'd0, led_o},  {31'd0, m_led});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_par(input int k, input int on_v, input int off_v, input int bl);
        on_t[k*16 +: 16]  = 16'(on_v);
        off_t[k*16 +: 16] = 16'(off_v);
        blinks[k*8 +: 8]  = 8'(bl);
    endtask

    task automatic measure(input logic lvl, output int n);
        n = 0;
        while ((led_o == lvl) && (n < 1000)) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_gnt(output logic [3:0] g);
        int n = 0;
        while ((gnt_o == 4'b0) && (n < 500)) begin
            @(negedge clk);
            n++;
        end
        if (gnt_o == 4'b0) chk("gnt_timeout", 32'd0, 32'd1);
        g = gnt_o;
    endtask

    task automatic wait_done(output logic [3:0] d, output int n);
        n = 0;
        while ((done_o == 4'b0) && (n < 1000)) begin
            @(negedge clk);
            n++;
        end
        if (done_o == 4'b0) chk("done_timeout", 32'd0, 32'd1);
        d = done_o;
    endtask

    task automatic wait_led;
        int n = 0;
        while (!led_o && (n < 500)) begin
            @(negedge clk);
            n++;
        end
        if (!led_o) chk("led_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] g, d;
        logic [3:0] order [5];
        int n;
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;

        rst = 1'b1; req = '0; on_t = '0; off_t = '0; blinks = '0;
        repeat (3) @(negedge clk);
        chk("reset_gnt",  {28'd0, gnt_o},  32'd0);
        chk("reset_done", {28'd0, done_o}, 32'd0);
        chk("reset_busy", {31'd0, busy_o}, 32'd0);
        chk("reset_led",  {31'd0, led_o},  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: single request, on=2 off=3 blinks=2
        set_par(0, 2, 3, 2);
        req = 4'b0001;
        @(negedge clk); chk("t1_gnt_c1", {28'd0, gnt_o}, 32'd0);
        @(negedge clk); chk("t1_gnt_c2", {28'd0, gnt_o}, 32'd1);
        chk("t1_led_c2", {31'd0, led_o}, 32'd0);
        @(negedge clk); chk("t1_led_c3", {31'd0, led_o}, 32'd1);
        measure(1'b1, n); chk("t1_on1_len", n, 32'd20);
        measure(1'b0, n); chk("t1_off1_len", n, 32'd30);
        measure(1'b1, n); chk("t1_on2_len", n, 32'd20);
        wait_done(d, n);  chk("t1_off2_len", n, 32'd30);
        chk("t1_done", {28'd0, d}, 32'd1);
        req = 4'b0;
        @(negedge clk);
        chk("t1_done_pulse", {28'd0, done_o}, 32'd0);
        chk("t1_busy_after", {31'd0, busy_o}, 32'd0);

        // 2: round robin with all four requesting
        do_reset();
        for (int k = 0; k < N; k++) set_par(k, 1, 1, 1);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_gnt(g);
            chk("t2_order", {28'd0, g}, {28'd0, order[i]});
            wait_done(d, n);
            chk("t2_done_bit", {28'd0, d}, {28'd0, order[i]});
            if (i == 4) req = 4'b0;
            @(negedge clk);
            chk("t2_done_pulse", {28'd0, done_o}, 32'd0);
        end

        // 3: zero blinks on requester 2
        set_par(2, 5, 5, 0);
        req = 4'b0100;
        @(negedge clk); chk("t3_done_c1", {28'd0, done_o}, 32'd0);
        @(negedge clk); chk("t3_gnt_c2",  {28'd0, gnt_o},  32'h4);
        @(negedge clk); chk("t3_done_c3", {28'd0, done_o}, 32'h4);
        req = 4'b0;
        @(negedge clk);

        // 4: abort requester 1 mid-ON, requester 3 pending
        set_par(1, 3, 1, 2);
        set_par(3, 1, 1, 1);
        req = 4'b0010;
        wait_gnt(g); chk("t4_gnt1", {28'd0, g}, 32'h2);
        req[3] = 1'b1;
        wait_led();
        repeat (5) @(negedge clk);
        req[1] = 1'b0;
        @(negedge clk);
        chk("t4_abort_led",  {31'd0, led_o},  32'd0);
        chk("t4_abort_gnt",  {28'd0, gnt_o},  32'd0);
        chk("t4_abort_done", {28'd0, done_o}, 32'd0);
        @(negedge clk);
        @(negedge clk); chk("t4_gnt3", {28'd0, gnt_o}, 32'h8);
        wait_done(d, n); chk("t4_done3", {28'd0, d}, 32'h8);
        req = 4'b0;
        @(negedge clk);

        // 5: zero on/off times behave as one tick
        set_par(0, 0, 0, 3);
        req = 4'b0001;
        wait_led();
        measure(1'b1, n); chk("t5_on1",  n, 32'd10);
        measure(1'b0, n); chk("t5_off1", n, 32'd10);
        measure(1'b1, n); chk("t5_on2",  n, 32'd10);
        measure(1'b0, n); chk("t5_off2", n, 32'd10);
        measure(1'b1, n); chk("t5_on3",  n, 32'd10);
        wait_done(d, n);  chk("t5_off3", n, 32'd10);
        req = 4'b0;
        @(negedge clk);

        // 6: reset mid-OFF, then clean restart
        set_par(0, 1, 2, 2);
        req = 4'b0001;
        wait_led();
        measure(1'b1, n); chk("t6_on_pre", n, 32'd10);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_rst_gnt",  {28'd0, gnt_o},  32'd0);
        chk("t6_rst_led",  {31'd0, led_o},  32'd0);
        chk("t6_rst_busy", {31'd0, busy_o}, 32'd0);
        chk("t6_rst_done", {28'd0, done_o}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); chk("t6_gnt_c1", {28'd0, gnt_o}, 32'd0);
        @(negedge clk); chk("t6_gnt_c2", {28'd0, gnt_o}, 32'd1);
        @(negedge clk); chk("t6_led_c3", {31'd0, led_o}, 32'd1);
        measure(1'b1, n); chk("t6_on1",  n, 32'd10);
        measure(1'b0, n); chk("t6_off1", n, 32'd20);
        measure(1'b1, n); chk("t6_on2",  n, 32'd10);
        wait_done(d, n);  chk("t6_off2", n, 32'd20);
        chk("t6_done", {28'd0, d}, 32'd1);
        req = 4'b0;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
